// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - unified byte memory serving data-cache reads/writes and instruction burst refills
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'b00
`endif
`ifndef MEM_DATA_WORKING
`define MEM_DATA_WORKING 2'b01
`endif
`ifndef MEM_INST_WORKING
`define MEM_INST_WORKING 2'b10
`endif
`ifndef BYTE
`define BYTE 3'b000
`endif
`ifndef HALF
`define HALF 3'b001
`endif
`ifndef WORD
`define WORD 3'b010
`endif

module main_memory_responder #(
   parameter int    ADDR_WIDTH       = 17,
   parameter int    LEN              = 32,
   parameter int    BYTE_SIZE        = 8,
   parameter int    ENTRY_INDEX_SIZE = 3,
   parameter int    INST_BURST       = 4,
   parameter string INIT_FILE        = "",
   localparam int   BW               = (INST_BURST > 1) ? $clog2(INST_BURST) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  mem_vis_signal,
   input  logic [ADDR_WIDTH-1:0]       mem_vis_addr,
   input  logic [LEN-1:0]              mem_writen_data,
   input  logic [2:0]                  written_data_type,
   input  logic [ENTRY_INDEX_SIZE:0]   write_length,
   output logic [LEN-1:0]              mem_data,
   output logic [1:0]                  mem_status,
   input  logic                        inst_req,
   input  logic [ADDR_WIDTH-1:0]       inst_addr,
   output logic [LEN-1:0]              inst_data,
   output logic                        inst_data_valid,
   output logic [BW-1:0]               inst_beat,
   output logic                        inst_done
);
   localparam int            NB        = LEN / BYTE_SIZE;
   localparam logic [BW-1:0] LAST_BEAT = BW'(INST_BURST - 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   logic [BYTE_SIZE-1:0]  r_mem [0:(1<<ADDR_WIDTH)-1];
   state_t                r_state, w_state_nxt;
   logic [BW-1:0]         r_beat, w_beat_nxt, r_inst_beat;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [LEN-1:0]        r_mem_data, r_inst_data, w_rd_word, w_burst_word;
   logic [1:0]            r_status, w_status_nxt;
   logic                  r_valid, r_done, w_valid_nxt, w_done_nxt;
   logic                  w_do_read, w_do_write, w_load_base;
   logic [ADDR_WIDTH-1:0] w_rd_base, w_burst_addr;
   logic [2:0]            w_wr_count;
   logic                  w_unused;

   assign w_rd_base    = {mem_vis_addr[ADDR_WIDTH-1:2], 2'b00};
   assign w_burst_addr = r_base + {{(ADDR_WIDTH-BW-2){1'b0}}, r_beat, 2'b00};
   assign w_unused     = &{1'b0, inst_addr[BW+1:0]};

   always_comb begin
      case (written_data_type)
         `BYTE:   w_wr_count = 3'd1;
         `HALF:   w_wr_count = 3'd2;
         `WORD:   w_wr_count = 3'd4;
         default: w_wr_count = 3'd0;
      endcase
   end

   // Memory order: the lowest byte address lands in the most significant byte lane.
   always_comb begin
      w_rd_word    = '0;
      w_burst_word = '0;
      for (int i = 0; i < NB; i++) begin
         w_rd_word[LEN-1-i*BYTE_SIZE -: BYTE_SIZE]    = r_mem[w_rd_base + ADDR_WIDTH'(i)];
         w_burst_word[LEN-1-i*BYTE_SIZE -: BYTE_SIZE] = r_mem[w_burst_addr + ADDR_WIDTH'(i)];
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_beat_nxt   = r_beat;
      w_status_nxt = `MEM_RESTING;
      w_valid_nxt  = 1'b0;
      w_done_nxt   = 1'b0;
      w_do_read    = 1'b0;
      w_do_write   = 1'b0;
      w_load_base  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_vis_signal == `MEM_READ) begin
               w_do_read    = 1'b1;
               w_status_nxt = `MEM_DATA_WORKING;
            end else if (mem_vis_signal == `MEM_WRITE) begin
               w_do_write   = (w_wr_count != 3'd0);
               w_status_nxt = `MEM_DATA_WORKING;
            end else if (inst_req) begin
               w_load_base  = 1'b1;
               w_beat_nxt   = '0;
               w_state_nxt  = S_BURST;
               w_status_nxt = `MEM_INST_WORKING;
            end
         end
         S_BURST: begin
            w_valid_nxt = 1'b1;
            if (r_beat == LAST_BEAT) begin
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_IDLE;
               w_status_nxt = `MEM_RESTING;
            end else begin
               w_beat_nxt   = r_beat + BW'(1);
               w_status_nxt = `MEM_INST_WORKING;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_base      <= '0;
         r_status    <= `MEM_RESTING;
         r_mem_data  <= '0;
         r_inst_data <= '0;
         r_inst_beat <= '0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_beat   <= w_beat_nxt;
         r_status <= w_status_nxt;
         r_valid  <= w_valid_nxt;
         r_done   <= w_done_nxt;
         if (w_load_base)
            r_base <= {inst_addr[ADDR_WIDTH-1:BW+2], {(BW+2){1'b0}}};
         if (w_do_read)
            r_mem_data <= w_rd_word;
         if (r_state == S_BURST) begin
            r_inst_data <= w_burst_word;
            r_inst_beat <= r_beat;
         end
      end
   end

   // Byte writes start at the full address and wrap naturally at the top of the space.
   always_ff @(posedge clk) begin
      if (rst_n && w_do_write) begin
         if (w_wr_count >= 3'd1)
            r_mem[mem_vis_addr] <= mem_writen_data[LEN-1 -: BYTE_SIZE];
         if (w_wr_count >= 3'd2)
            r_mem[mem_vis_addr + ADDR_WIDTH'(1)] <= mem_writen_data[LEN-1-BYTE_SIZE -: BYTE_SIZE];
         if (w_wr_count >= 3'd4) begin
            r_mem[mem_vis_addr + ADDR_WIDTH'(2)] <= mem_writen_data[LEN-1-2*BYTE_SIZE -: BYTE_SIZE];
            r_mem[mem_vis_addr + ADDR_WIDTH'(3)] <= mem_writen_data[LEN-1-3*BYTE_SIZE -: BYTE_SIZE];
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == S_BURST && (mem_vis_signal == `MEM_READ || mem_vis_signal == `MEM_WRITE))
            $display("warning: data request ignored during instruction burst");
         if (r_state == S_IDLE && mem_vis_signal == `MEM_WRITE) begin
            if (write_length != (ENTRY_INDEX_SIZE+1)'(1))
               $display("warning: write_length %0d treated as 1", write_length);
            if (w_wr_count == 3'd0)
               $display("warning: unknown written_data_type %0d, no write", written_data_type);
         end
         if (r_state == S_IDLE && mem_vis_signal == 2'b11)
            $display("warning: mem_vis_signal 2'b11 treated as NOP");
      end
   end
`endif

   assign mem_data        = r_mem_data;
   assign mem_status      = r_status;
   assign inst_data       = r_inst_data;
   assign inst_data_valid = r_valid;
   assign inst_beat       = r_inst_beat;
   assign inst_done       = r_done;
endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - self-checking bench for main_memory_responder
module tb_main_memory_responder;
   localparam int AW = 17;
   localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, BAD = 2'b11;
   localparam logic [1:0] ST_REST = 2'b00, ST_DATA = 2'b01, ST_INST = 2'b10;
   localparam logic [2:0] T_BYTE = 3'd0, T_HALF = 3'd1, T_WORD = 3'd2, T_BAD = 3'd7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    mem_vis_signal;
   logic [AW-1:0] mem_vis_addr;
   logic [31:0]   mem_writen_data;
   logic [2:0]    written_data_type;
   logic [3:0]    write_length;
   logic [31:0]   mem_data;
   logic [1:0]    mem_status;
   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic [31:0]   inst_data;
   logic          inst_data_valid;
   logic [1:0]    inst_beat;
   logic          inst_done;

   main_memory_responder dut (
      .clk(clk), .rst_n(rst_n),
      .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
      .mem_writen_data(mem_writen_data), .written_data_type(written_data_type),
      .write_length(write_length), .mem_data(mem_data), .mem_status(mem_status),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data),
      .inst_data_valid(inst_data_valid), .inst_beat(inst_beat), .inst_done(inst_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    sig;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [2:0]    typ;
      logic [3:0]    wl;
      logic [31:0]   exp;
   } vec_t;
   typedef struct { logic [1:0] st; logic [31:0] md; } sb_t;
   typedef struct { logic [1:0] beat; logic [31:0] data; logic done; } beat_t;

   vec_t        tbl[$];
   sb_t         sb[$];
   beat_t       bq[$];
   logic [31:0] exp_md = 32'h0;
   int          checks = 0;
   int          failures = 0;

   function automatic vec_t mk(input logic [1:0] s, input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [2:0] t, input logic [3:0] l, input logic [31:0] e);
      vec_t v;
      v.sig = s; v.addr = a; v.wdata = d; v.typ = t; v.wl = l; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      sb_t e;
      mem_vis_signal    = v.sig;
      mem_vis_addr      = v.addr;
      mem_writen_data   = v.wdata;
      written_data_type = v.typ;
      write_length      = v.wl;
      e.st = (v.sig == RD || v.sig == WR) ? ST_DATA : ST_REST;
      if (v.sig == RD) exp_md = v.exp;
      e.md = exp_md;
      sb.push_back(e);
   endtask

   task automatic tick(input string nm);
      sb_t e;
      @(posedge clk);
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({nm, "_status"}, 32'(mem_status), 32'(e.st));
         chk({nm, "_data"}, mem_data, e.md);
      end
   endtask

   task automatic push_beats(input logic [AW-1:0] base);
      beat_t b;
      for (int i = 0; i < 4; i++) begin
         b.beat = 2'(i);
         b.data = 32'hC0DE0000 | 32'(base + AW'(4*i));
         b.done = (i == 3);
         bq.push_back(b);
      end
   endtask

   task automatic burst_collect(input string nm);
      beat_t e;
      int cyc = 0;
      while (bq.size() > 0 && cyc < 12) begin
         @(posedge clk);
         @(negedge clk);
         mem_vis_signal = NOP;
         cyc++;
         chk({nm, "_valid"}, 32'(inst_data_valid), 32'd1);
         if (inst_data_valid) begin
            e = bq.pop_front();
            chk({nm, "_beat"}, 32'(inst_beat), 32'(e.beat));
            chk({nm, "_word"}, inst_data, e.data);
            chk({nm, "_done"}, 32'(inst_done), 32'(e.done));
            chk({nm, "_status"}, 32'(mem_status), e.done ? 32'(ST_REST) : 32'(ST_INST));
         end
      end
      if (bq.size() > 0) begin
         chk({nm, "_timeout_beats_left"}, 32'(bq.size()), 32'd0);
         bq.delete();
      end
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_after_valid"}, 32'(inst_data_valid), 32'd0);
      chk({nm, "_after_done"}, 32'(inst_done), 32'd0);
      chk({nm, "_after_status"}, 32'(mem_status), 32'(ST_REST));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      mem_vis_signal = NOP; mem_vis_addr = '0; mem_writen_data = '0;
      written_data_type = T_WORD; write_length = 4'd1; inst_req = 1'b0; inst_addr = '0;

      tbl.push_back(mk(WR,  17'h00104, 32'h0,        T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h00108, 32'h0,        T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h0010C, 32'h0,        T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h00100, 32'h11223344, T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(RD,  17'h00102, 32'h0,        T_WORD, 4'd1, 32'h11223344));
      tbl.push_back(mk(WR,  17'h00103, 32'hAB000000, T_BYTE, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h00107, 32'hCDEF0000, T_HALF, 4'd1, 32'h0));
      tbl.push_back(mk(RD,  17'h00104, 32'h0,        T_WORD, 4'd1, 32'h000000CD));
      tbl.push_back(mk(RD,  17'h00108, 32'h0,        T_WORD, 4'd1, 32'hEF000000));
      tbl.push_back(mk(RD,  17'h00100, 32'h0,        T_WORD, 4'd1, 32'h112233AB));
      tbl.push_back(mk(WR,  17'h00100, 32'hFFFFFFFF, T_BAD,  4'd1, 32'h0));
      tbl.push_back(mk(RD,  17'h00100, 32'h0,        T_WORD, 4'd1, 32'h112233AB));
      tbl.push_back(mk(WR,  17'h1FFFC, 32'h0,        T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h00000, 32'h0,        T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h1FFFE, 32'hA1B2C3D4, T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(RD,  17'h1FFFC, 32'h0,        T_WORD, 4'd1, 32'h0000A1B2));
      tbl.push_back(mk(RD,  17'h00001, 32'h0,        T_WORD, 4'd1, 32'hC3D40000));
      tbl.push_back(mk(NOP, 17'h00100, 32'h0,        T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(BAD, 17'h00100, 32'h0,        T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h0010B, 32'h9A5B0000, T_BYTE, 4'd2, 32'h0));
      tbl.push_back(mk(RD,  17'h00108, 32'h0,        T_WORD, 4'd1, 32'hEF00009A));
      tbl.push_back(mk(RD,  17'h0010C, 32'h0,        T_WORD, 4'd1, 32'h00000000));
      tbl.push_back(mk(WR,  17'h00200, 32'hC0DE0200, T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h00204, 32'hC0DE0204, T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h00208, 32'hC0DE0208, T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h0020C, 32'hC0DE020C, T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(WR,  17'h00040, 32'h55667788, T_WORD, 4'd1, 32'h0));
      tbl.push_back(mk(RD,  17'h0020C, 32'h0,        T_WORD, 4'd1, 32'hC0DE020C));
      tbl.push_back(mk(NOP, 17'h0,     32'h0,        T_WORD, 4'd1, 32'h0));

      repeat (2) @(negedge clk);
      chk("rst_mem_data", mem_data, 32'h0);
      chk("rst_status", 32'(mem_status), 32'(ST_REST));
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_valid_done_beat", {29'h0, inst_data_valid, inst_done, 1'b0} | 32'(inst_beat), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         tick($sformatf("vec%0d", i));
      end

      // Refill from a mid-line address: base aligns down to 0x200.
      inst_req = 1'b1; inst_addr = 17'h0020C;
      push_beats(17'h00200);
      @(posedge clk); @(negedge clk);
      inst_req = 1'b0;
      chk("burst1_accept_status", 32'(mem_status), 32'(ST_INST));
      chk("burst1_accept_valid", 32'(inst_data_valid), 32'd0);
      burst_collect("burst1");

      // Data request and inst_req together: data first, burst one cycle later.
      inst_req = 1'b1; inst_addr = 17'h00200;
      drive(mk(RD, 17'h00040, 32'h0, T_WORD, 4'd1, 32'h55667788));
      tick("same_read");
      chk("same_read_no_beat", 32'(inst_data_valid), 32'd0);
      mem_vis_signal = NOP;
      @(posedge clk); @(negedge clk);
      inst_req = 1'b0;
      chk("same_accept_status", 32'(mem_status), 32'(ST_INST));
      mem_vis_signal = RD; mem_vis_addr = 17'h00100;
      push_beats(17'h00200);
      burst_collect("burst2");
      chk("ignored_read_data", mem_data, 32'h55667788);

      // Reset while beat 1 is on the outputs.
      inst_req = 1'b1; inst_addr = 17'h00208;
      @(posedge clk); @(negedge clk);
      inst_req = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rb_beat0_valid", 32'(inst_data_valid), 32'd1);
      @(posedge clk); @(negedge clk);
      chk("rb_beat1_beat", 32'(inst_beat), 32'd1);
      chk("rb_beat1_word", inst_data, 32'hC0DE0204);
      rst_n = 1'b0;
      #1;
      chk("rb_valid", 32'(inst_data_valid), 32'd0);
      chk("rb_status", 32'(mem_status), 32'(ST_REST));
      chk("rb_mem_data", mem_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_md = 32'h0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         if (inst_data_valid || inst_done) seen = 1'b1;
      end
      chk("rb_no_more_beats", 32'(seen), 32'd0);
      drive(mk(RD, 17'h00204, 32'h0, T_WORD, 4'd1, 32'hC0DE0204));
      tick("rb_mem_kept0");
      drive(mk(RD, 17'h00001, 32'h0, T_WORD, 4'd1, 32'hC3D40000));
      tick("rb_mem_kept1");
      mem_vis_signal = NOP;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
